security_zone_fsm: RTL and testbench

Parametrised, multi-zone successor to the single-sensor security FSM with timer. It watches `N_ZONES` sensor inputs while armed. Delayed zones start an entry-delay countdown; instant zones raise the alarm at once. The siren stays latched until a valid disarm. It sits between the debounced sensor/keypad front end and the siren/indicator drivers, and it contains its own countdown timer, so no external timer block is needed.

---
 rtl/security_zone_fsm.sv | 145 ++++++++++++++
 tb/tb_security_zone_fsm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/security_zone_fsm.sv
// Multi-zone armed/entry/alarm controller with built-in entry countdown and latched siren.
// Optional exit delay after arming is enabled by defining SECURITY_EXIT_DELAY_EN.
module security_zone_fsm #(
  parameter int                 N_ZONES      = 4,
  parameter int                 TW           = 8,
  parameter int                 ENTRY_DELAY  = 20,
  parameter int                 EXIT_DELAY   = 30,
  parameter logic [N_ZONES-1:0] INSTANT_MASK = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               disarm,
  input  logic [N_ZONES-1:0] zone,
  output logic               armed,
  output logic               timer_on,
  output logic               siren,
  output logic [TW-1:0]      remaining,
  output logic [N_ZONES-1:0] zone_latched
);

  // Parameter sanity checks, resolved at elaboration.
  if (N_ZONES < 1 || N_ZONES > 16) begin : g_bad_nzones
    $error("security_zone_fsm: N_ZONES must be 1..16");
  end
  if (ENTRY_DELAY < 1 || ENTRY_DELAY > (2**TW) - 1) begin : g_bad_entry
    $error("security_zone_fsm: ENTRY_DELAY out of range for TW");
  end
  if (EXIT_DELAY < 1 || EXIT_DELAY > (2**TW) - 1) begin : g_bad_exit
    $error("security_zone_fsm: EXIT_DELAY out of range for TW");
  end

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_ALARM    = 3'd3
`ifdef SECURITY_EXIT_DELAY_EN
    ,
    ST_EXIT     = 3'd4
`endif
  } state_t;

  localparam logic [TW-1:0] LP_ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
`ifdef SECURITY_EXIT_DELAY_EN
  localparam logic [TW-1:0] LP_EXIT_LOAD  = TW'(EXIT_DELAY - 1);
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TW-1:0]        r_cnt;
  logic [TW-1:0]        w_cnt_nxt;
  logic [N_ZONES-1:0]   r_latched;
  logic [N_ZONES-1:0]   w_latched_nxt;
  logic [N_ZONES-1:0]   w_inst;
  logic [N_ZONES-1:0]   w_dly;

  assign w_inst = zone & INSTANT_MASK;
  assign w_dly  = zone & ~INSTANT_MASK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_DISARMED;
      r_cnt     <= '0;
      r_latched <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_latched <= w_latched_nxt;
    end
  end

  // The zero test precedes the decrement, so the counter never wraps.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_latched_nxt = r_latched;
    if (disarm) begin
      w_state_nxt = ST_DISARMED;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_DISARMED: begin
          if (arm) begin
            w_latched_nxt = '0;
`ifdef SECURITY_EXIT_DELAY_EN
            w_state_nxt   = ST_EXIT;
            w_cnt_nxt     = LP_EXIT_LOAD;
`else
            w_state_nxt   = ST_ARMED;
            w_cnt_nxt     = '0;
`endif
          end
        end
`ifdef SECURITY_EXIT_DELAY_EN
        ST_EXIT: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_cnt_nxt = r_cnt - TW'(1);
          end
        end
`endif
        ST_ARMED: begin
          w_latched_nxt = r_latched | zone;
          if (|w_inst) begin
            w_state_nxt = ST_ALARM;
          end else if (|w_dly) begin
            w_state_nxt = ST_ENTRY;
            w_cnt_nxt   = LP_ENTRY_LOAD;
          end
        end
        ST_ENTRY: begin
          w_latched_nxt = r_latched | zone;
          if (|w_inst) begin
            w_state_nxt = ST_ALARM;
            w_cnt_nxt   = '0;
          end else if (r_cnt == '0) begin
            w_state_nxt = ST_ALARM;
          end else begin
            w_cnt_nxt = r_cnt - TW'(1);
          end
        end
        ST_ALARM: begin
          w_latched_nxt = r_latched | zone;
        end
        default: begin
          w_state_nxt = ST_DISARMED;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign armed = (r_state == ST_ARMED) || (r_state == ST_ENTRY) || (r_state == ST_ALARM);
  assign siren = (r_state == ST_ALARM);
`ifdef SECURITY_EXIT_DELAY_EN
  assign timer_on = (r_state == ST_ENTRY) || (r_state == ST_EXIT);
`else
  assign timer_on = (r_state == ST_ENTRY);
`endif
  assign remaining    = timer_on ? r_cnt : '0;
  assign zone_latched = r_latched;

endmodule

// File: tb/tb_security_zone_fsm.sv
// Scoreboard bench for security_zone_fsm: a deadline-based reference model predicts
// every post-edge output; a monitor pops and compares after each clock or reset edge.
module tb_security_zone_fsm;
  localparam int             N  = 4;
  localparam int             TW = 8;
  localparam int             ED = 20;
  localparam int             XD = 30;
  localparam logic [N-1:0]   IM = 4'b1000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic [N-1:0]  zone = '0;
  logic          armed;
  logic          timer_on;
  logic          siren;
  logic [TW-1:0] remaining;
  logic [N-1:0]  zone_latched;

  security_zone_fsm #(
    .N_ZONES(N), .TW(TW), .ENTRY_DELAY(ED), .EXIT_DELAY(XD), .INSTANT_MASK(IM)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .disarm(disarm), .zone(zone),
    .armed(armed), .timer_on(timer_on), .siren(siren),
    .remaining(remaining), .zone_latched(zone_latched)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int            tag;
    logic          armed;
    logic          timer_on;
    logic          siren;
    logic [TW-1:0] rem;
    logic [N-1:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   tag = 0;

  // Reference model: absolute edge numbers for deadlines instead of a counter.
  int           n = 0;
  bit           m_on = 1'b0;
  bit           m_alarm = 1'b0;
  int           m_ready_at = -1;
  int           m_alarm_at = -1;
  logic [N-1:0] m_lat = '0;

  function automatic exp_t model_outputs();
    exp_t e;
    bit   exiting;
    bit   entry;
    int   r;
    exiting = m_on && (m_ready_at >= 0) && (n < m_ready_at);
    entry   = m_on && !exiting && !m_alarm && (m_alarm_at >= 0);
    r = exiting ? (m_ready_at - 1 - n) : (entry ? (m_alarm_at - 1 - n) : 0);
    e.tag      = tag;
    e.armed    = m_on && !exiting;
    e.timer_on = exiting || entry;
    e.siren    = m_alarm;
    e.rem      = TW'(r);
    e.lat      = m_lat;
    return e;
  endfunction

  task automatic model_edge(input bit a, input bit d, input logic [N-1:0] z);
    if (d) begin
      m_on = 1'b0; m_alarm = 1'b0; m_alarm_at = -1; m_ready_at = -1;
    end else if (!m_on) begin
      if (a) begin
        m_on = 1'b1; m_alarm = 1'b0; m_alarm_at = -1; m_lat = '0;
`ifdef SECURITY_EXIT_DELAY_EN
        m_ready_at = n + XD;
`else
        m_ready_at = -1;
`endif
      end
    end else if (m_ready_at >= 0 && n <= m_ready_at) begin
      // still leaving the premises: zones are ignored
    end else begin
      m_lat = m_lat | z;
      if (!m_alarm) begin
        if ((z & IM) != '0) m_alarm = 1'b1;
        else if (m_alarm_at >= 0) begin
          if (n == m_alarm_at) m_alarm = 1'b1;
        end else if ((z & ~IM) != '0) m_alarm_at = n + ED;
      end
    end
    sb_q.push_back(model_outputs());
    n++;
    tag++;
  endtask

  task automatic step(input bit a, input bit d, input logic [N-1:0] z);
    @(negedge clk);
    arm = a; disarm = d; zone = z;
    model_edge(a, d, z);
  endtask

  task automatic pulse_reset();
    exp_t e;
    @(negedge clk);
    arm = 1'b0; disarm = 1'b0; zone = '0;
    #2;
    m_on = 1'b0; m_alarm = 1'b0; m_alarm_at = -1; m_ready_at = -1; m_lat = '0;
    e = model_outputs();
    sb_q.push_back(e);
    tag++;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  always begin
    @(posedge clk or posedge reset);
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      total++;
      if ({armed, timer_on, siren, remaining, zone_latched} !==
          {mon_e.armed, mon_e.timer_on, mon_e.siren, mon_e.rem, mon_e.lat}) begin
        bad++;
        $display("FAIL outputs item=%0d got armed=%b timer_on=%b siren=%b rem=%0d lat=%b need armed=%b timer_on=%b siren=%b rem=%0d lat=%b",
                 mon_e.tag, armed, timer_on, siren, remaining, zone_latched,
                 mon_e.armed, mon_e.timer_on, mon_e.siren, mon_e.rem, mon_e.lat);
      end
    end
  end

  initial begin
    logic [N-1:0] rz;
    int           waited;
    pulse_reset();

    // Delayed zone: countdown 19..0, siren 20 edges after trigger.
    step(1, 0, '0);
    step(0, 0, 4'b0010);
    repeat (22) step(0, 0, '0);
    step(0, 1, '0);

    // Disarm 10 edges into the entry delay.
    step(1, 0, '0);
    step(0, 0, 4'b0001);
    repeat (9) step(0, 0, '0);
    step(0, 1, '0);
    repeat (3) step(0, 0, '0);

    // Instant zone during ENTRY cuts the countdown short.
    step(1, 0, '0);
    step(0, 0, 4'b0001);
    repeat (5) step(0, 0, '0);
    step(0, 0, 4'b1000);
    step(0, 0, '0);
    step(0, 1, '0);

    // Disarm and violation on the same edge.
    step(1, 0, '0);
    step(0, 1, 4'b0100);
    step(0, 0, '0);

    // Asynchronous reset mid-entry, then re-arm.
    step(1, 0, '0);
    step(0, 0, 4'b0010);
    repeat (6) step(0, 0, '0);
    pulse_reset();
    step(0, 0, '0);
    step(1, 0, '0);
    step(0, 0, '0);

    // Latched zones survive disarm and are cleared by the next arm.
    step(0, 0, 4'b0101);
    step(0, 1, '0);
    step(0, 0, '0);
    step(1, 0, '0);
    step(0, 0, '0);
    step(0, 1, '0);

`ifdef SECURITY_EXIT_DELAY_EN
    // Exit delay: violations ignored, armed after XD edges, then entry works.
    step(1, 0, '0);
    repeat (10) step(0, 0, 4'b0011);
    repeat (22) step(0, 0, '0);
    step(0, 0, 4'b0001);
    repeat (22) step(0, 0, '0);
    step(0, 1, '0);
    step(1, 0, '0);
    repeat (4) step(0, 0, '0);
    step(0, 1, '0);
`endif

    repeat (1500) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        for (int b = 0; b < N; b++) rz[b] = ($urandom_range(0, 24) == 0);
        step($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, rz);
      end
    end
    step(0, 0, '0);

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got %0d pending items need 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
